// File: rtl/march_bist_ctrl.sv
// March C- memory BIST controller: sequences reads/writes over the whole array for
// up to four data backgrounds and records the first mismatch plus a saturating count.
module march_bist_ctrl #(
  parameter int DTA_SIZE    = 8,
  parameter int ADR_SIZE    = 4,
  parameter int NUM_BG      = 1,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADR_SIZE-1:0] mem_adr,
  output logic [DTA_SIZE-1:0] mem_wdata,
  output logic                mem_wr_en,
  output logic                mem_rd_en,
  input  logic [DTA_SIZE-1:0] mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [ADR_SIZE-1:0] err_adr,
  output logic [DTA_SIZE-1:0] err_syn,
  output logic [2:0]          err_elem,
  output logic [1:0]          err_bg,
  output logic [7:0]          err_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic PH_RD = 1'b0;
  localparam logic PH_WR = 1'b1;

  localparam logic [1:0] BG_LAST = 2'(NUM_BG - 1);

  function automatic logic [DTA_SIZE-1:0] bg_pattern(input logic [1:0] bg);
    logic [DTA_SIZE-1:0] p;
    p = '0;
    for (int i = 0; i < DTA_SIZE; i++) begin
      case (bg)
        2'd1:    p[i] = ~i[0];
        2'd2:    p[i] = ~i[1];
        2'd3:    p[i] = ~i[2];
        default: p[i] = 1'b0;
      endcase
    end
    return p;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [2:0]          elem_q, elem_d;
  logic                ph_q, ph_d;
  logic [ADR_SIZE-1:0] adr_q, adr_d;
  logic [1:0]          bg_q, bg_d;
  logic                fail_q, fail_d;
  logic [ADR_SIZE-1:0] err_adr_q, err_adr_d;
  logic [DTA_SIZE-1:0] err_syn_q, err_syn_d;
  logic [2:0]          err_elem_q, err_elem_d;
  logic [1:0]          err_bg_q, err_bg_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic                vld_p1_q, vld_p1_d;
  logic [DTA_SIZE-1:0] exp_p1_q, exp_p1_d;
  logic [ADR_SIZE-1:0] adr_p1_q, adr_p1_d;
  logic [2:0]          elem_p1_q, elem_p1_d;
  logic [1:0]          bg_p1_q, bg_p1_d;

  logic                run, two_cycle, is_down, addr_end;
  logic                op_rd, op_wr, mis;
  logic [DTA_SIZE-1:0] pat, rd_exp, wr_dat, syn;

  always_comb begin
    run       = (state_q == S_RUN);
    two_cycle = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    is_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
    addr_end  = is_down ? (adr_q == '0) : (adr_q == '1);
    op_rd     = run && ((elem_q == 3'd5) || (two_cycle && (ph_q == PH_RD)));
    op_wr     = run && !op_rd;
    pat       = bg_pattern(bg_q);
    rd_exp    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~pat : pat;
    wr_dat    = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~pat : pat;
    syn       = mem_rdata ^ exp_p1_q;
    mis       = vld_p1_q && ((state_q == S_RUN) || (state_q == S_FLUSH)) && (syn != '0);
  end

  // Stage p0 -> p1: remember what each read should return, compared when rdata lands
  always_comb begin
    vld_p1_d  = op_rd;
    exp_p1_d  = rd_exp;
    adr_p1_d  = adr_q;
    elem_p1_d = elem_q;
    bg_p1_d   = bg_q;
  end

  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    ph_d       = ph_q;
    adr_d      = adr_q;
    bg_d       = bg_q;
    fail_d     = fail_q;
    err_adr_d  = err_adr_q;
    err_syn_d  = err_syn_q;
    err_elem_d = err_elem_q;
    err_bg_d   = err_bg_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RUN;
          elem_d     = 3'd0;
          ph_d       = PH_RD;
          adr_d      = '0;
          bg_d       = 2'd0;
          fail_d     = 1'b0;
          err_adr_d  = '0;
          err_syn_d  = '0;
          err_elem_d = 3'd0;
          err_bg_d   = 2'd0;
          err_cnt_d  = 8'd0;
        end
      end
      S_RUN: begin
        if (two_cycle && (ph_q == PH_RD)) begin
          ph_d = PH_WR;
        end else begin
          ph_d = PH_RD;
          if (!addr_end) begin
            adr_d = is_down ? adr_q - 1'b1 : adr_q + 1'b1;
          end else if (elem_q == 3'd5) begin
            elem_d = 3'd0;
            adr_d  = '0;
            if (bg_q == BG_LAST) state_d = S_FLUSH;
            else                 bg_d    = bg_q + 2'd1;
          end else begin
            elem_d = elem_q + 3'd1;
            // M3 and M4 walk downwards, so they start from the top address
            adr_d  = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? '1 : '0;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (mis) begin
      fail_d    = 1'b1;
      err_cnt_d = sat_inc(err_cnt_q);
      if (!fail_q) begin
        err_adr_d  = adr_p1_q;
        err_syn_d  = syn;
        err_elem_d = elem_p1_q;
        err_bg_d   = bg_p1_q;
      end
      if (STOP_ON_ERR != 0) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      elem_q     <= 3'd0;
      ph_q       <= PH_RD;
      adr_q      <= '0;
      bg_q       <= 2'd0;
      fail_q     <= 1'b0;
      err_adr_q  <= '0;
      err_syn_q  <= '0;
      err_elem_q <= 3'd0;
      err_bg_q   <= 2'd0;
      err_cnt_q  <= 8'd0;
      vld_p1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      ph_q       <= ph_d;
      adr_q      <= adr_d;
      bg_q       <= bg_d;
      fail_q     <= fail_d;
      err_adr_q  <= err_adr_d;
      err_syn_q  <= err_syn_d;
      err_elem_q <= err_elem_d;
      err_bg_q   <= err_bg_d;
      err_cnt_q  <= err_cnt_d;
      vld_p1_q   <= vld_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    exp_p1_q  <= exp_p1_d;
    adr_p1_q  <= adr_p1_d;
    elem_p1_q <= elem_p1_d;
    bg_p1_q   <= bg_p1_d;
  end

  always_comb begin
    mem_adr   = run ? adr_q : '0;
    mem_wdata = op_wr ? wr_dat : '0;
    mem_wr_en = op_wr;
    mem_rd_en = op_rd;
    busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
    done      = (state_q == S_DONE);
    fail      = fail_q;
    err_adr   = err_adr_q;
    err_syn   = err_syn_q;
    err_elem  = err_elem_q;
    err_bg    = err_bg_q;
    err_cnt   = err_cnt_q;
  end

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Bench for march_bist_ctrl: three instances (1 bg, 4 bg, 1 bg stop-on-error) each driving
// a small faulty memory; expectations from a table and from a March C- operation-list model.
module tb_march_bist_ctrl;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       st   [3];
  logic [3:0] m_adr[3];
  logic [7:0] m_wd [3];
  logic       wr   [3];
  logic       rd   [3];
  logic [7:0] m_rd [3];
  logic       bsy  [3];
  logic       dn   [3];
  logic       fl   [3];
  logic [3:0] ea   [3];
  logic [7:0] es   [3];
  logic [2:0] ee   [3];
  logic [1:0] eb   [3];
  logic [7:0] ec   [3];

  march_bist_ctrl #(.DTA_SIZE(8), .ADR_SIZE(4), .NUM_BG(1), .STOP_ON_ERR(0)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .mem_adr(m_adr[0]), .mem_wdata(m_wd[0]),
    .mem_wr_en(wr[0]), .mem_rd_en(rd[0]), .mem_rdata(m_rd[0]), .busy(bsy[0]), .done(dn[0]),
    .fail(fl[0]), .err_adr(ea[0]), .err_syn(es[0]), .err_elem(ee[0]), .err_bg(eb[0]), .err_cnt(ec[0]));
  march_bist_ctrl #(.DTA_SIZE(8), .ADR_SIZE(4), .NUM_BG(4), .STOP_ON_ERR(0)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .mem_adr(m_adr[1]), .mem_wdata(m_wd[1]),
    .mem_wr_en(wr[1]), .mem_rd_en(rd[1]), .mem_rdata(m_rd[1]), .busy(bsy[1]), .done(dn[1]),
    .fail(fl[1]), .err_adr(ea[1]), .err_syn(es[1]), .err_elem(ee[1]), .err_bg(eb[1]), .err_cnt(ec[1]));
  march_bist_ctrl #(.DTA_SIZE(8), .ADR_SIZE(4), .NUM_BG(1), .STOP_ON_ERR(1)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .mem_adr(m_adr[2]), .mem_wdata(m_wd[2]),
    .mem_wr_en(wr[2]), .mem_rd_en(rd[2]), .mem_rdata(m_rd[2]), .busy(bsy[2]), .done(dn[2]),
    .fail(fl[2]), .err_adr(ea[2]), .err_syn(es[2]), .err_elem(ee[2]), .err_bg(eb[2]), .err_cnt(ec[2]));

  // Memories with stuck-at bits: masked bits always store the fault value
  logic [7:0] mem   [3][N];
  logic [7:0] fmask [3][N];
  logic [7:0] fval  [3][N];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wr[i]) mem[i][m_adr[i]] <= (m_wd[i] & ~fmask[i][m_adr[i]]) | (fval[i][m_adr[i]] & fmask[i][m_adr[i]]);
      if (rd[i]) m_rd[i] <= mem[i][m_adr[i]];
    end
  end

  typedef struct { bit wr; int adr; logic [7:0] d; int elem; int bg; } op_t;
  typedef struct { bit fail; int adr; logic [7:0] syn; int elem; int bg; int cnt; int done_k; } res_t;
  typedef struct { int inst; int fa; logic [7:0] fm; logic [7:0] fv; res_t exp; } vec_t;

  int   nbg_of [3] = '{1, 4, 1};
  bit   stop_of[3] = '{1'b0, 1'b0, 1'b1};
  op_t  ops[$];
  int   nexec;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_faults(input int inst, input int fa, input logic [7:0] fm, input logic [7:0] fv);
    for (int a = 0; a < N; a++) begin
      fmask[inst][a] = ((fa == -1) || (fa == a)) ? fm : 8'h00;
      fval[inst][a]  = ((fa == -1) || (fa == a)) ? fv : 8'h00;
    end
  endtask

  // Build the full March C- operation list, then replay it on an ideal faulty memory
  task automatic model(input int inst, output res_t r);
    logic [7:0] pats[4];
    logic [7:0] m[N];
    logic [7:0] p, rexp, fmk, fvl;
    op_t o;
    int a;
    pats = '{8'h00, 8'h55, 8'h33, 8'h0F};
    ops.delete();
    for (int b = 0; b < nbg_of[inst]; b++) begin
      p = pats[b];
      for (int e = 0; e < 6; e++) begin
        for (int i = 0; i < N; i++) begin
          a = (e == 3 || e == 4) ? N - 1 - i : i;
          o.adr = a; o.elem = e; o.bg = b;
          if (e == 0) begin
            o.wr = 1'b1; o.d = p; ops.push_back(o);
          end else if (e == 5) begin
            o.wr = 1'b0; o.d = p; ops.push_back(o);
          end else begin
            rexp = (e == 1 || e == 3) ? p : ~p;
            o.wr = 1'b0; o.d = rexp;  ops.push_back(o);
            o.wr = 1'b1; o.d = ~rexp; ops.push_back(o);
          end
        end
      end
    end
    r.fail = 1'b0; r.adr = 0; r.syn = 8'h00; r.elem = 0; r.bg = 0; r.cnt = 0;
    r.done_k = ops.size() + 1;
    nexec = ops.size();
    for (int k = 0; k < ops.size(); k++) begin
      o   = ops[k];
      fmk = fmask[inst][o.adr];
      fvl = fval[inst][o.adr];
      if (o.wr) begin
        m[o.adr] = (o.d & ~fmk) | (fvl & fmk);
      end else if (m[o.adr] != o.d) begin
        if (!r.fail) begin
          r.fail = 1'b1; r.adr = o.adr; r.syn = m[o.adr] ^ o.d; r.elem = o.elem; r.bg = o.bg;
        end
        if (r.cnt < 255) r.cnt++;
        if (stop_of[inst]) begin
          r.done_k = k + 2;
          nexec = (k + 2 < ops.size()) ? k + 2 : ops.size();
          break;
        end
      end
    end
  endtask

  task automatic run(input int inst, input res_t e, input string tag);
    int  done_k;
    int  bad;
    op_t o;
    done_k = -1;
    bad = 0;
    @(negedge clk); st[inst] = 1'b1;
    @(negedge clk); st[inst] = 1'b0;
    chk({tag, "_clr"}, {fl[inst], ec[inst], dn[inst], bsy[inst]}, 11'h001);
    for (int k = 0; k < 700; k++) begin
      if (k > 0) @(negedge clk);
      if (dn[inst]) begin
        done_k = k;
        break;
      end
      if (!bsy[inst]) bad++;
      if (k < nexec) begin
        o = ops[k];
        if (wr[inst] != o.wr || rd[inst] != !o.wr || m_adr[inst] != o.adr[3:0] ||
            (o.wr && m_wd[inst] != o.d)) bad++;
      end else if (wr[inst] || rd[inst]) begin
        bad++;
      end
    end
    chk({tag, "_trace"}, bad, 0);
    chk({tag, "_done_k"}, done_k, e.done_k);
    chk({tag, "_idle"}, {bsy[inst], wr[inst], rd[inst]}, 0);
    chk({tag, "_fail"}, fl[inst], e.fail);
    chk({tag, "_cnt"}, ec[inst], e.cnt);
    chk({tag, "_adr"}, ea[inst], e.adr);
    chk({tag, "_syn"}, es[inst], e.syn);
    chk({tag, "_elem"}, ee[inst], e.elem);
    chk({tag, "_bg"}, eb[inst], e.bg);
  endtask

  function automatic vec_t mk(int inst, int fa, logic [7:0] fm, logic [7:0] fv, bit f, int adr,
                              logic [7:0] syn, int elem, int bg, int cnt, int dk);
    vec_t v;
    v.inst = inst; v.fa = fa; v.fm = fm; v.fv = fv;
    v.exp.fail = f; v.exp.adr = adr; v.exp.syn = syn; v.exp.elem = elem;
    v.exp.bg = bg; v.exp.cnt = cnt; v.exp.done_k = dk;
    return v;
  endfunction

  task automatic chk_all_zero(input string name);
    for (int i = 0; i < 3; i++)
      chk(name, {bsy[i], dn[i], fl[i], ea[i], es[i], ee[i], eb[i], ec[i], m_adr[i], m_wd[i], wr[i], rd[i]}, 0);
  endtask

  vec_t vecs[8];
  res_t r;

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      set_faults(i, -2, 8'h00, 8'h00);
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    rst = 1'b1;

    vecs[0] = mk(0, -2, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0,   0, 161);
    vecs[1] = mk(0,  5, 8'h01, 8'h01, 1, 5, 8'h01, 1, 0,   3, 161);
    vecs[2] = mk(2,  5, 8'h01, 8'h01, 1, 5, 8'h01, 1, 0,   1,  28);
    vecs[3] = mk(1, -2, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0,   0, 641);
    vecs[4] = mk(1,  5, 8'h01, 8'h01, 1, 5, 8'h01, 1, 0,   9, 641);
    vecs[5] = mk(1,  9, 8'h80, 8'h00, 1, 9, 8'h80, 2, 0,   8, 641);
    vecs[6] = mk(2,  9, 8'h80, 8'h00, 1, 9, 8'h80, 2, 0,   1,  68);
    vecs[7] = mk(1, -1, 8'hFF, 8'hA5, 1, 0, 8'hA5, 1, 0, 255, 641);
    for (int v = 0; v < 8; v++) begin
      set_faults(vecs[v].inst, vecs[v].fa, vecs[v].fm, vecs[v].fv);
      model(vecs[v].inst, r);
      run(vecs[v].inst, vecs[v].exp, $sformatf("vec%0d", v));
    end

    for (int t = 0; t < 6; t++) begin
      int inst;
      int nf;
      inst = $urandom_range(0, 2);
      set_faults(inst, -2, 8'h00, 8'h00);
      nf = $urandom_range(0, 3);
      for (int j = 0; j < nf; j++) begin
        int fa;
        fa = $urandom_range(0, N - 1);
        fmask[inst][fa] = 8'($urandom_range(1, 255));
        fval[inst][fa]  = 8'($urandom_range(0, 255));
      end
      model(inst, r);
      run(inst, r, $sformatf("rnd%0d", t));
    end

    // Abort a failing test with reset, then a clean run must see nothing of it
    set_faults(0, 0, 8'h01, 8'h01);
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    repeat (49) @(posedge clk);
    @(negedge clk);
    chk("pre_rst", {bsy[0], fl[0]}, 2'b11);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(negedge clk); rst = 1'b1;
    set_faults(0, -2, 8'h00, 8'h00);
    model(0, r);
    run(0, r, "post_rst");

    // start held high: no restart while busy, second test at the edge after done rises
    begin
      int done_k;
      done_k = -1;
      @(negedge clk); st[0] = 1'b1;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (dn[0]) begin
          done_k = k;
          break;
        end
      end
      chk("held_done_k", done_k, 161);
      @(negedge clk);
      chk("held_restart", {bsy[0], dn[0], wr[0], rd[0], m_adr[0]}, 8'b1010_0000);
      st[0] = 1'b0;
      done_k = -1;
      for (int k = 1; k < 300; k++) begin
        @(negedge clk);
        if (dn[0]) begin
          done_k = k;
          break;
        end
      end
      chk("held_second_done_k", done_k, 161);
      chk("held_second_cnt", {fl[0], ec[0]}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/march_bist_ctrl.md
MARCH_BIST_CTRL -- requirements
Module: march_bist_ctrl

Interface
REQ-001 Parameter DTA_SIZE, default 8, memory data width in bits (2..32).
REQ-002 Parameter ADR_SIZE, default 4, memory address width; depth N = 2^ADR_SIZE.
REQ-003 Parameter NUM_BG, default 1, number of data backgrounds run per test (1..4).
REQ-004 Parameter STOP_ON_ERR, default 0; 1 = end the test at the first detected mismatch.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  test request, sampled only in IDLE.
REQ-008 mem_adr  out  ADR_SIZE  memory address.
REQ-009 mem_wdata  out  DTA_SIZE  memory write data.
REQ-010 mem_wr_en  out  1  memory write strobe, one word per cycle.
REQ-011 mem_rd_en  out  1  memory read strobe.
REQ-012 mem_rdata  in  DTA_SIZE  read data, valid exactly one cycle after mem_rd_en.
REQ-013 busy  out  1  test in progress.
REQ-014 done  out  1  test finished; level, held until next accepted start.
REQ-015 fail  out  1  sticky: at least one mismatch in the current or last test.
REQ-016 err_adr  out  ADR_SIZE  address of first mismatch.
REQ-017 err_syn  out  DTA_SIZE  first mismatch syndrome (expected XOR read).
REQ-018 err_elem  out  3  March element index (0..5) of first mismatch.
REQ-019 err_bg  out  2  background index of first mismatch.
REQ-020 err_cnt  out  8  mismatch count, saturating at 255.

Function
REQ-021 Algorithm March C- per background B: M0 up(wB); M1 up(rB,w~B); M2 up(r~B,wB); M3 down(rB,w~B); M4 down(r~B,wB); M5 up(rB).
REQ-022 Backgrounds in order idx0..NUM_BG-1: all-zeros, 0101.. (LSB 1), 0011.. (LSBs 11), 00001111.. (low nibble 1), each replicated/truncated to DTA_SIZE.
REQ-023 States: IDLE, RUN (sub-counters element 0..5, phase RD/WR, address), FLUSH (last read compare), DONE.
REQ-024 Up elements address 0..N-1, down elements N-1..0; address counter wraps only at element boundaries.
REQ-025 Elements M1..M4 take 2 cycles per address: read cycle then write cycle at same address; M0 and M5 take 1 cycle per address.
REQ-026 Exactly one of mem_wr_en/mem_rd_en high per RUN cycle; both low in IDLE, FLUSH, DONE.
REQ-027 T = 10*N*NUM_BG operation cycles; edge E0 accepts start (busy=1, done=0, fail=0, err_cnt=0, err_* =0); operation k driven during cycle after edge E0+k.
REQ-028 Each read compared against expected data in the cycle mem_rdata is valid; result registered at the following edge.
REQ-029 Final M5 read of last background compared in FLUSH; at edge E0+T+1 busy=0, done=1.
REQ-030 Mismatch: fail=1, err_cnt+1 (saturate); err_adr/err_syn/err_elem/err_bg loaded only if fail was 0.
REQ-031 STOP_ON_ERR=1: first registered mismatch forces DONE at that edge; no further memory strobes.
REQ-032 start while busy or with start held high in DONE across the same edge as done rising: ignored; new test requires start sampled in IDLE or DONE.
REQ-033 start sampled in DONE restarts a test exactly as from IDLE.

Reset
REQ-034 rst low at any time, including mid-test: immediate return to IDLE; all outputs 0; mem strobes deasserted asynchronously.
REQ-035 After rst release, first start is accepted on the first rising edge with start=1.

Verification (DTA_SIZE=8, ADR_SIZE=4, N=16)
REQ-036 Fault-free memory, NUM_BG=1, start pulse -> busy 161 cycles, done=1 at E0+161, fail=0, err_cnt=0; 16 writes of 0x00 first, last op read adr 15.
REQ-037 Stuck-at-1 bit0 at adr 5, NUM_BG=1 -> fail=1, err_adr=5, err_syn=0x01, err_elem=1, err_bg=0, err_cnt=3 (M1, M3, M5 reads of 0x00).
REQ-038 Same fault, STOP_ON_ERR=1 -> done at edge after M1 read of adr 5 registers; no strobes after; err_cnt=1.
REQ-039 NUM_BG=4 fault-free -> T=640, done at E0+641; M0 of bg1 writes 0x55, bg2 0x33, bg3 0x0F.
REQ-040 rst pulsed low at E0+50 -> all outputs 0 immediately; new start afterwards runs full 161-cycle test, results unaffected by aborted run.
REQ-041 start held high throughout -> one test only while busy; second test begins at edge after done rises.
